// File: rtl/my_mod_ctrl_if.sv
// Generator-side bundle for my_mod_ctrl: modulation config in, applied config and
// sample-window controls out. The slave modport is the controller, the master the driver.
interface my_mod_ctrl_if;
    logic               i_cfg_valid;
    logic        [31:0] i_freq_cnt_new;
    logic signed [31:0] i_amp_H_new;
    logic signed [31:0] i_amp_L_new;
    logic               i_run;
    logic        [15:0] i_settle_cnt;
    logic               i_stepTrig;
    logic               i_status;

    logic        [31:0] o_freq_cnt;
    logic signed [31:0] o_amp_H;
    logic signed [31:0] o_amp_L;
    logic               o_cfg_ack;
    logic               o_cfg_pending;
    logic               o_smp_en;
    logic               o_smp_sign;
    logic               o_settle_err;
    logic        [15:0] o_half_cnt;

    modport slave (
        input  i_cfg_valid, i_freq_cnt_new, i_amp_H_new, i_amp_L_new,
               i_run, i_settle_cnt, i_stepTrig, i_status,
        output o_freq_cnt, o_amp_H, o_amp_L, o_cfg_ack, o_cfg_pending,
               o_smp_en, o_smp_sign, o_settle_err, o_half_cnt
    );

    modport master (
        output i_cfg_valid, i_freq_cnt_new, i_amp_H_new, i_amp_L_new,
               i_run, i_settle_cnt, i_stepTrig, i_status,
        input  o_freq_cnt, o_amp_H, o_amp_L, o_cfg_ack, o_cfg_pending,
               o_smp_en, o_smp_sign, o_settle_err, o_half_cnt
    );
endinterface

// File: rtl/my_mod_ctrl.sv
// Modulation controller: shadowed config applied at positive half-cycle steps, plus settle/sample window sequencer.
// Latency: config, ack, window and error outputs all update one clock after the triggering input edge.
// Backpressure: none; all inputs are strobes/levels and are consumed on the cycle they are presented.
module my_mod_ctrl #(
    parameter logic        [31:0] P_FREQ_RST  = 32'd100,
    parameter logic signed [31:0] P_AMP_H_RST = 32'sd8192,
    parameter logic signed [31:0] P_AMP_L_RST = -32'sd8192
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    my_mod_ctrl_if.slave bus
);
    typedef struct packed {
        logic [31:0] freq;
        logic [31:0] amp_h;
        logic [31:0] amp_l;
    } cfg_t;

    localparam cfg_t RST_CFG = '{freq: P_FREQ_RST, amp_h: P_AMP_H_RST, amp_l: P_AMP_L_RST};

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE} state_e;

    cfg_t   shadow_q, shadow_d, applied_q, applied_d;
    logic   pend_q, pend_d, ack_q, ack_d;
    state_e state_q, state_d;
    logic [15:0] cnt_q, cnt_d, half_q, half_d;
    logic   sign_q, sign_d, err_q, err_d;
    logic   apply;

    // Apply reads the old shadow, so a same-cycle capture survives as the next pending config.
    assign apply = bus.i_stepTrig & bus.i_status & pend_q;

    always_comb begin
        shadow_d  = shadow_q;
        applied_d = applied_q;
        pend_d    = pend_q;
        ack_d     = 1'b0;
        if (apply) begin
            applied_d = shadow_q;
            ack_d     = 1'b1;
            pend_d    = 1'b0;
        end
        if (bus.i_cfg_valid) begin
            shadow_d = '{freq: bus.i_freq_cnt_new, amp_h: bus.i_amp_H_new, amp_l: bus.i_amp_L_new};
            pend_d   = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        err_d   = 1'b0;
        half_d  = half_q;
        if (!bus.i_run) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (bus.i_stepTrig) begin
            half_d  = half_q + 16'd1;
            cnt_d   = bus.i_settle_cnt;
            sign_d  = bus.i_status;
            err_d   = (state_q == S_SETTLE);
            state_d = (bus.i_settle_cnt == 16'd0) ? S_SAMPLE : S_SETTLE;
        end else if (state_q == S_SETTLE) begin
            // Leaving on count 1 yields exactly i_settle_cnt blanked clocks.
            cnt_d = cnt_q - 16'd1;
            if (cnt_q == 16'd1) begin
                state_d = S_SAMPLE;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shadow_q  <= RST_CFG;
            applied_q <= RST_CFG;
            pend_q    <= 1'b0;
            ack_q     <= 1'b0;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            err_q     <= 1'b0;
            half_q    <= '0;
        end else begin
            shadow_q  <= shadow_d;
            applied_q <= applied_d;
            pend_q    <= pend_d;
            ack_q     <= ack_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sign_q    <= sign_d;
            err_q     <= err_d;
            half_q    <= half_d;
        end
    end

    assign bus.o_freq_cnt    = applied_q.freq;
    assign bus.o_amp_H       = $signed(applied_q.amp_h);
    assign bus.o_amp_L       = $signed(applied_q.amp_l);
    assign bus.o_cfg_ack     = ack_q;
    assign bus.o_cfg_pending = pend_q;
    assign bus.o_smp_en      = (state_q == S_SAMPLE);
    assign bus.o_smp_sign    = sign_q;
    assign bus.o_settle_err  = err_q;
    assign bus.o_half_cnt    = half_q;
endmodule

// File: tb/tb_my_mod_ctrl.sv
// Directed and randomized bench for my_mod_ctrl against a cycle-level reference model.
module tb_my_mod_ctrl;
    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    my_mod_ctrl_if bus();

    my_mod_ctrl dut (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus));

    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;

    // Reference model: blanking is "clocks left before sampling" once a window is active.
    logic [31:0] m_freq, m_ah, m_al, m_sh_f, m_sh_h, m_sh_l;
    logic        m_pend, m_ack, m_sign, m_err, m_active;
    int          m_blank;
    logic [15:0] m_half;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_freq = 32'd100; m_ah = 32'd8192; m_al = -32'sd8192;
        m_sh_f = m_freq;  m_sh_h = m_ah;   m_sh_l = m_al;
        m_pend = 0; m_ack = 0; m_sign = 0; m_err = 0; m_active = 0; m_blank = 0; m_half = 0;
    endtask

    task automatic model_update();
        bit apply;
        apply = bus.i_stepTrig && bus.i_status && m_pend;
        m_ack = apply;
        if (apply) begin
            m_freq = m_sh_f; m_ah = m_sh_h; m_al = m_sh_l; m_pend = 0;
        end
        if (bus.i_cfg_valid) begin
            m_sh_f = bus.i_freq_cnt_new; m_sh_h = bus.i_amp_H_new; m_sh_l = bus.i_amp_L_new; m_pend = 1;
        end
        m_err = 0;
        if (!bus.i_run) begin
            m_active = 0; m_blank = 0;
        end else if (bus.i_stepTrig) begin
            m_err    = m_active && (m_blank > 0);
            m_active = 1;
            m_blank  = int'(bus.i_settle_cnt);
            m_sign   = bus.i_status;
            m_half   = m_half + 16'd1;
        end else if (m_active && m_blank > 0) begin
            m_blank--;
        end
    endtask

    task automatic check_all();
        chk("freq",    bus.o_freq_cnt,    m_freq);
        chk("amp_H",   bus.o_amp_H,       m_ah);
        chk("amp_L",   bus.o_amp_L,       m_al);
        chk("ack",     32'(bus.o_cfg_ack),     32'(m_ack));
        chk("pending", 32'(bus.o_cfg_pending), 32'(m_pend));
        chk("smp_en",  32'(bus.o_smp_en),      32'(m_active && m_blank == 0));
        chk("sign",    32'(bus.o_smp_sign),    32'(m_sign));
        chk("err",     32'(bus.o_settle_err),  32'(m_err));
        chk("half",    32'(bus.o_half_cnt),    32'(m_half));
    endtask

    task automatic tick(input bit do_chk);
        model_update();
        @(posedge i_clk);
        #1;
        if (do_chk) check_all();
    endtask

    task automatic drive_cfg(input logic [31:0] f, input logic [31:0] h, input logic [31:0] l);
        bus.i_cfg_valid = 1'b1; bus.i_freq_cnt_new = f; bus.i_amp_H_new = h; bus.i_amp_L_new = l;
    endtask

    task automatic quiet();
        bus.i_cfg_valid = 1'b0; bus.i_stepTrig = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_freq"},  bus.o_freq_cnt, 32'd100);
        chk({tag, "_ampH"},  bus.o_amp_H,    32'h0000_2000);
        chk({tag, "_ampL"},  bus.o_amp_L,    32'hFFFF_E000);
        chk({tag, "_pend"},  32'(bus.o_cfg_pending), 32'd0);
        chk({tag, "_smpen"}, 32'(bus.o_smp_en),      32'd0);
        chk({tag, "_half"},  32'(bus.o_half_cnt),    32'd0);
        chk({tag, "_err"},   32'(bus.o_settle_err),  32'd0);
    endtask

    initial begin
        bus.i_cfg_valid = 0; bus.i_freq_cnt_new = 0; bus.i_amp_H_new = 0; bus.i_amp_L_new = 0;
        bus.i_run = 0; bus.i_settle_cnt = 0; bus.i_stepTrig = 0; bus.i_status = 0;
        model_reset();
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        check_reset_outputs("rst");
        for (int i = 0; i < 3; i++) tick(1);

        // Config waits for a positive-half step, then applies atomically.
        drive_cfg(32'd200, 32'd4000, -32'sd4000); tick(1);
        quiet();
        chk("cfg_pend", 32'(bus.o_cfg_pending), 32'd1);
        bus.i_stepTrig = 1; bus.i_status = 0; tick(1);
        chk("neg_step_freq", bus.o_freq_cnt, 32'd100);
        chk("neg_step_ack", 32'(bus.o_cfg_ack), 32'd0);
        bus.i_status = 1; tick(1);
        chk("apply_ack", 32'(bus.o_cfg_ack), 32'd1);
        chk("apply_freq", bus.o_freq_cnt, 32'd200);
        chk("apply_ampH", bus.o_amp_H, 32'd4000);
        chk("apply_ampL", bus.o_amp_L, 32'hFFFF_F060);
        quiet(); tick(1);
        chk("ack_pulse", 32'(bus.o_cfg_ack), 32'd0);

        // Last write wins.
        drive_cfg(32'd300, 32'd1, 32'd2); tick(1);
        drive_cfg(32'd400, 32'd3, 32'd4); tick(1);
        chk("lww_no_ack", 32'(bus.o_cfg_ack), 32'd0);
        quiet(); bus.i_stepTrig = 1; bus.i_status = 1; tick(1);
        chk("lww_freq", bus.o_freq_cnt, 32'd400);
        quiet(); tick(1);

        // Capture coinciding with apply.
        drive_cfg(32'd500, 32'd5, 32'd6); tick(1);
        drive_cfg(32'd600, 32'd7, 32'd8); bus.i_stepTrig = 1; bus.i_status = 1; tick(1);
        chk("coinc_freq", bus.o_freq_cnt, 32'd500);
        chk("coinc_pend", 32'(bus.o_cfg_pending), 32'd1);
        bus.i_cfg_valid = 0; tick(1);
        chk("coinc_next", bus.o_freq_cnt, 32'd600);
        quiet(); tick(1);

        // Settle 5: five blanked clocks then sampling with positive sign.
        bus.i_run = 1; bus.i_settle_cnt = 16'd5; bus.i_status = 1; bus.i_stepTrig = 1; tick(1);
        chk("blank0", 32'(bus.o_smp_en), 32'd0);
        quiet();
        for (int i = 1; i < 5; i++) begin
            tick(1);
            chk("blank", 32'(bus.o_smp_en), 32'd0);
        end
        tick(1);
        chk("sample_en", 32'(bus.o_smp_en), 32'd1);
        chk("sample_sign", 32'(bus.o_smp_sign), 32'd1);
        for (int i = 0; i < 3; i++) tick(1);

        // Early step during settle restarts 10-clock blanking.
        bus.i_settle_cnt = 16'd10; bus.i_status = 0; bus.i_stepTrig = 1; tick(1);
        quiet();
        for (int i = 0; i < 3; i++) tick(1);
        bus.i_stepTrig = 1; tick(1);
        chk("settle_err", 32'(bus.o_settle_err), 32'd1);
        quiet(); tick(1);
        chk("settle_err_pulse", 32'(bus.o_settle_err), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("reblank", 32'(bus.o_smp_en), 32'd0);
        end
        tick(1);
        chk("reblank_done", 32'(bus.o_smp_en), 32'd1);

        // Run drop wins over a concurrent step.
        bus.i_run = 0; bus.i_stepTrig = 1; tick(1);
        chk("run_drop", 32'(bus.o_smp_en), 32'd0);
        quiet(); tick(1);

        // Asynchronous reset mid-settle with a pending config.
        bus.i_run = 1; bus.i_settle_cnt = 16'd5; bus.i_stepTrig = 1; tick(1);
        quiet(); drive_cfg(32'd777, 32'd9, 32'd9); tick(1);
        quiet();
        #2 i_rst_n = 1'b0;
        #1;
        check_reset_outputs("arst");
        model_reset();
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        tick(1);
        check_reset_outputs("post_rst");

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            bus.i_run          = ($urandom_range(0, 7) != 0);
            bus.i_stepTrig     = ($urandom_range(0, 3) == 0);
            bus.i_status       = $urandom_range(0, 1);
            bus.i_cfg_valid    = ($urandom_range(0, 5) == 0);
            bus.i_settle_cnt   = 16'($urandom_range(0, 6));
            bus.i_freq_cnt_new = $urandom;
            bus.i_amp_H_new    = $urandom;
            bus.i_amp_L_new    = $urandom;
            tick(1);
        end

        // Half-cycle counter wraps after 65536 steps.
        quiet(); bus.i_run = 1; bus.i_settle_cnt = 16'd0; tick(1);
        begin
            logic [15:0] h0;
            h0 = bus.o_half_cnt;
            bus.i_stepTrig = 1;
            for (int i = 0; i < 65536; i++) tick(0);
            chk("half_wrap", 32'(bus.o_half_cnt), 32'(h0));
        end
        check_all();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/my_mod_ctrl.md
MY_MOD_CTRL -- requirements
Module: my_mod_ctrl

Interface
REQ-001 Parameter P_FREQ_RST, default 32'd100, o_freq_cnt value after reset.
REQ-002 Parameter P_AMP_H_RST, default 32'sd8192, o_amp_H value after reset.
REQ-003 Parameter P_AMP_L_RST, default -32'sd8192, o_amp_L value after reset.
REQ-004 Port i_clk  input  1  single system clock; all logic on rising edge.
REQ-005 Port i_rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port i_cfg_valid  input  1  one-cycle strobe: new modulation config present.
REQ-007 Port i_freq_cnt_new  input  32  requested half-cycle length count.
REQ-008 Port i_amp_H_new / i_amp_L_new  input  32 signed each  requested half-cycle amplitudes.
REQ-009 Port i_run  input  1  level; enables the sample-window sequencer.
REQ-010 Port i_settle_cnt  input  16  clocks to blank after each half-cycle step.
REQ-011 Port i_stepTrig  input  1  step pulse from the modulation generator.
REQ-012 Port i_status  input  1  generator polarity (1 = positive half, 0 = negative half).
REQ-013 Port o_freq_cnt  output  32  applied half-cycle count, drives generator.
REQ-014 Port o_amp_H / o_amp_L  output  32 signed each  applied amplitudes, drive generator.
REQ-015 Port o_cfg_ack  output  1  one-cycle pulse when a pending config is applied.
REQ-016 Port o_cfg_pending  output  1  shadow config captured, not yet applied.
REQ-017 Port o_smp_en  output  1  demodulator accumulate enable.
REQ-018 Port o_smp_sign  output  1  polarity of current sample window.
REQ-019 Port o_settle_err  output  1  one-cycle pulse: step arrived during SETTLE.
REQ-020 Port o_half_cnt  output  16  count of steps seen while i_run=1, wraps.

Function
REQ-021 Config capture: i_cfg_valid=1 SHALL register all three *_new inputs into shadow registers and set o_cfg_pending on the next edge.
REQ-022 i_cfg_valid while already pending SHALL overwrite the shadow (last write wins); pending stays 1, no ack.
REQ-023 Apply point: a cycle with i_stepTrig=1, i_status=1, pending=1 SHALL load shadow into o_freq_cnt/o_amp_H/o_amp_L, pulse o_cfg_ack, clear pending, all on the next edge.
REQ-024 i_stepTrig with i_status=0 SHALL NOT apply config; applied triple changes only atomically, never partially.
REQ-025 i_cfg_valid coinciding with an apply cycle: apply uses the previous shadow; the new data is captured and pending remains 1.
REQ-026 Config path SHALL operate regardless of i_run.
REQ-027 Sequencer FSM states: IDLE, SETTLE, SAMPLE; o_smp_en=1 only in SAMPLE (registered from state).
REQ-028 IDLE: i_run=1 and i_stepTrig=1 -> load 16-bit down-counter with i_settle_cnt, latch o_smp_sign<=i_status, go SETTLE; i_settle_cnt=0 -> go SAMPLE directly.
REQ-029 SETTLE: decrement each clock; transition to SAMPLE on the clock the counter reads 1 (exactly i_settle_cnt clocks of blanking).
REQ-030 SAMPLE: i_stepTrig=1 -> reload counter, relatch sign, go SETTLE (or stay SAMPLE with new sign if i_settle_cnt=0); o_smp_en SHALL be 0 the clock after the step when i_settle_cnt>0.
REQ-031 SETTLE with i_stepTrig=1: pulse o_settle_err, reload counter, relatch sign, remain SETTLE.
REQ-032 i_run=0 in any state -> IDLE next edge, o_smp_en=0; i_run takes priority over i_stepTrig.
REQ-033 o_half_cnt increments by 1 on each i_stepTrig with i_run=1, wraps 16'hFFFF->0, holds when i_run=0.

Reset
REQ-034 i_rst_n=0 SHALL asynchronously force: o_freq_cnt=P_FREQ_RST, o_amp_H=P_AMP_H_RST, o_amp_L=P_AMP_L_RST, shadows equal to these, pending=0, o_cfg_ack=0, FSM IDLE, o_smp_en=0, o_smp_sign=0, o_settle_err=0, o_half_cnt=0, counter=0.
REQ-035 Reset mid-SETTLE/SAMPLE or with pending config SHALL discard state; first activity after release is the next i_stepTrig.

Verification
REQ-036 Reset release, no stimulus -> outputs 100 / 8192 / -8192, o_smp_en=0, pending=0.
REQ-037 i_cfg_valid with 200/4000/-4000, then step with i_status=0, then step with i_status=1 -> no change at first step; ack pulse and 200/4000/-4000 one clock after second.
REQ-038 Two i_cfg_valid (300 then 400) before apply -> one ack, o_freq_cnt=400.
REQ-039 i_run=1, i_settle_cnt=5, step with i_status=1 -> o_smp_en low 5 clocks then high with o_smp_sign=1 until next step.
REQ-040 i_settle_cnt=10, second step 4 clocks after first -> o_settle_err single pulse, blanking restarts 10 clocks.
REQ-041 i_run dropped during SAMPLE -> o_smp_en=0 next clock; 65536 steps -> o_half_cnt returns to 0.
